mic_capture: RTL and testbench

Serial front end for the Pmod MIC3 (ADCS7476 12-bit ADC). Runs the SPI read frame (chip select, serial clock, data capture) at a fixed sample rate and presents each 12-bit sample with a one-cycle strobe. It also tracks a windowed peak. The peak output drives the volume-level and LED-bar logic through its `mic` input.

---
 rtl/mic_capture_pkg.sv | 10 +
 rtl/mic_capture_peak_hold.sv | 39 +++
 rtl/mic_capture.sv | 80 ++++++++
 tb/tb_mic_capture.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mic_capture_pkg.sv
// mic_capture_pkg: shared widths, FSM states and counter sizing for the MIC3 front end
package mic_capture_pkg;
  localparam int MIC_BITS = 12;
  localparam int MIC_FRAME_BITS = 16;
  localparam int MIC_LEAD_BITS = 4;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} mic_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mic_capture_peak_hold.sv
// mic_peak_hold: running max of accepted samples, published once per window
module mic_peak_hold import mic_capture_pkg::*; #(
  parameter int PEAK_WINDOW = 4000
) (
  input logic clk,
  input logic rst,
  input logic [MIC_BITS-1:0] sample,
  input logic sample_valid,
  output logic [MIC_BITS-1:0] peak,
  output logic peak_valid
);
  localparam int CW = cnt_w(PEAK_WINDOW);
  localparam logic [CW-1:0] LAST = CW'(PEAK_WINDOW - 1);
  logic [CW-1:0] cnt;
  logic [MIC_BITS-1:0] run_max;
  logic [MIC_BITS-1:0] new_max;
  logic wrap;
  // max including the incoming sample, and whether it closes the window
  always_comb begin
    new_max = sample > run_max ? sample : run_max;
    wrap = sample_valid && cnt == LAST;
  end
  // window counter, running max and published peak
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run_max <= '0;
      peak <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= wrap;
      if (wrap) peak <= new_max;
      if (sample_valid) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        run_max <= wrap ? '0 : new_max;
      end
    end
  end
endmodule

// File: rtl/mic_capture.sv
// mic_capture: ADCS7476 SPI read frame at a fixed sample rate with frame check and windowed peak
module mic_capture import mic_capture_pkg::*; #(
  parameter int SCLK_DIV = 16,
  parameter int SAMPLE_DIV = 5000,
  parameter int PEAK_WINDOW = 4000
) (
  input logic clk_100mhz,
  input logic rst,
  input logic mic_miso,
  output logic mic_cs_n,
  output logic mic_sclk,
  output logic [MIC_BITS-1:0] sample,
  output logic sample_valid,
  output logic frame_err,
  output logic [MIC_BITS-1:0] peak,
  output logic peak_valid
);
  localparam int PW = cnt_w(SAMPLE_DIV);
  localparam int HW = cnt_w(SCLK_DIV);
  localparam int BW = cnt_w(MIC_FRAME_BITS);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(MIC_FRAME_BITS - 1);
  mic_state_t state, state_d;
  logic [PW-1:0] per_cnt;
  logic [HW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;
  logic [MIC_FRAME_BITS-1:0] shift;
  logic tick, rise, last, accept, reject;
  // SCLK edge detection, next state and frame verdict
  always_comb begin
    tick = state == CONVERT && half_cnt == HALF_LAST;
    rise = tick && !mic_sclk;
    last = rise && bit_cnt == BIT_LAST;
    state_d = state == IDLE ? (per_cnt == '0 ? CONVERT : IDLE) :
              state == CONVERT ? (last ? DONE : CONVERT) : IDLE;
    accept = state == DONE && shift[MIC_FRAME_BITS-1 -: MIC_LEAD_BITS] == '0;
    reject = state == DONE && !accept;
  end
  // FSM state register
  always_ff @(posedge clk_100mhz) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  // free-running sample-period counter
  always_ff @(posedge clk_100mhz) begin
    if (rst) per_cnt <= '0;
    else per_cnt <= per_cnt == PER_LAST ? '0 : per_cnt + 1'b1;
  end
  // serial interface pins, shift register and sample register
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      mic_cs_n <= 1'b1;
      mic_sclk <= 1'b1;
      half_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mic_cs_n <= state_d == IDLE;
      mic_sclk <= state == CONVERT ? mic_sclk ^ tick : 1'b1;
      half_cnt <= state == CONVERT && !tick ? half_cnt + 1'b1 : '0;
      bit_cnt <= state != CONVERT ? '0 : rise ? bit_cnt + 1'b1 : bit_cnt;
      if (rise) shift <= {shift[MIC_FRAME_BITS-2:0], mic_miso};
      if (accept) sample <= shift[MIC_BITS-1:0];
      sample_valid <= accept;
      frame_err <= reject;
    end
  end
  mic_peak_hold #(.PEAK_WINDOW(PEAK_WINDOW)) u_peak (
    .clk(clk_100mhz),
    .rst(rst),
    .sample(shift[MIC_BITS-1:0]),
    .sample_valid(accept),
    .peak(peak),
    .peak_valid(peak_valid)
  );
endmodule

// File: tb/tb_mic_capture.sv
// tb_mic_capture: ADC word model plus scoreboard of expected strobes for mic_capture
module tb_mic_capture;
  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  logic mic_miso = 1'b0;
  logic mic_cs_n, mic_sclk, sample_valid, frame_err, peak_valid;
  logic [11:0] sample, peak;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [15:0] word;
    logic err;
    logic [11:0] smp;
    logic pv;
    logic [11:0] pk;
  } vec_t;
  vec_t exp_q[$];
  logic [15:0] words[$];
  int nframe = 0;
  bit cut = 1'b0;
  vec_t tbl [15] = '{
    '{16'h0A5C, 1'b0, 12'hA5C, 1'b0, 12'h000},
    '{16'h0123, 1'b0, 12'h123, 1'b0, 12'h000},
    '{16'h0FFF, 1'b0, 12'hFFF, 1'b0, 12'h000},
    '{16'h0123, 1'b0, 12'h123, 1'b1, 12'hFFF},
    '{16'h8ABC, 1'b1, 12'h123, 1'b0, 12'hFFF},
    '{16'h0800, 1'b0, 12'h800, 1'b0, 12'hFFF},
    '{16'h0F00, 1'b0, 12'hF00, 1'b0, 12'hFFF},
    '{16'h0900, 1'b0, 12'h900, 1'b0, 12'hFFF},
    '{16'h0810, 1'b0, 12'h810, 1'b1, 12'hF00},
    '{16'h0E00, 1'b0, 12'hE00, 1'b0, 12'hF00},
    '{16'h0DDD, 1'b0, 12'h000, 1'b0, 12'h000},
    '{16'h0100, 1'b0, 12'h100, 1'b0, 12'h000},
    '{16'h0200, 1'b0, 12'h200, 1'b0, 12'h000},
    '{16'h0050, 1'b0, 12'h050, 1'b0, 12'h000},
    '{16'h01FF, 1'b0, 12'h1FF, 1'b1, 12'h200}
  };

  always #5 clk_100mhz = ~clk_100mhz;

  mic_capture #(.PEAK_WINDOW(4)) dut (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .mic_miso(mic_miso),
    .mic_cs_n(mic_cs_n),
    .mic_sclk(mic_sclk),
    .sample(sample),
    .sample_valid(sample_valid),
    .frame_err(frame_err),
    .peak(peak),
    .peak_valid(peak_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // ADC model: MSB valid from the CS fall, next bit driven after each rising SCLK's following fall
  logic [15:0] cur = 16'h0;
  int rises = 0;
  bit m_cs = 1'b1;
  bit m_sclk = 1'b1;
  always @(posedge clk_100mhz) begin
    #1;
    if (m_cs && !mic_cs_n) begin
      cur = words.size() != 0 ? words.pop_front() : 16'h0;
      rises = 0;
      nframe++;
      mic_miso = cur[15];
    end else if (!mic_cs_n && !m_sclk && mic_sclk) rises++;
    else if (!mic_cs_n && m_sclk && !mic_sclk) mic_miso = cur[15 - rises];
    m_cs = mic_cs_n;
    m_sclk = mic_sclk;
  end

  // monitor: frame timing checks and scoreboard pops on every strobe
  int cyc = 0;
  int fall_cyc = 0;
  bit have_fall = 1'b0;
  bit skip = 1'b0;
  bit prev_cs = 1'b1;
  vec_t e;
  always @(posedge clk_100mhz) begin
    #1;
    cyc++;
    if (prev_cs && !mic_cs_n) begin
      if (have_fall && !skip) chk("frame_period", cyc - fall_cyc, 5000);
      have_fall = 1'b1;
      skip = 1'b0;
      fall_cyc = cyc;
    end
    if (!prev_cs && mic_cs_n) begin
      chk("cs_low_cycles", cyc - fall_cyc, cut ? 200 : 513);
      chk("sclk_rises", rises, cut ? 6 : 16);
      if (cut) skip = 1'b1;
    end
    if (sample_valid === 1'b1 || frame_err === 1'b1 || peak_valid === 1'b1) begin
      chk("valid_and_err_together", {31'b0, sample_valid & frame_err}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got sv=%b err=%b pv=%b sample=0x%0h expected no strobe",
                 sample_valid, frame_err, peak_valid, sample);
      end else begin
        e = exp_q.pop_front();
        chk("frame_err", frame_err, e.err);
        chk("sample_valid", sample_valid, !e.err);
        chk("sample", sample, e.smp);
        chk("peak_valid", peak_valid, e.pv);
        chk("peak", peak, e.pk);
        chk("strobe_edge", cyc - fall_cyc, 513);
      end
    end
    prev_cs = mic_cs_n;
  end

  // stimulus: queue words/expectations, run reset checks and the mid-frame reset
  initial begin
    foreach (tbl[i]) begin
      words.push_back(tbl[i].word);
      if (i != 10) exp_q.push_back(tbl[i]);
    end
    repeat (5) @(posedge clk_100mhz);
    #1;
    chk("rst_cs_n", mic_cs_n, 1);
    chk("rst_sclk", mic_sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_peak", peak, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_peak_valid", peak_valid, 0);
    rst = 1'b0;
    @(posedge clk_100mhz);
    #1;
    chk("first_frame_cs_n", mic_cs_n, 0);
    for (int i = 0; i < 60000 && nframe < 11; i++) @(posedge clk_100mhz);
    if (nframe < 11) begin
      checks++;
      failures++;
      $display("FAIL wait_frame11: got %0d frames expected 11", nframe);
    end else begin
      cut = 1'b1;
      repeat (198) @(posedge clk_100mhz);
      #1;
      rst = 1'b1;
      @(posedge clk_100mhz);
      #1;
      chk("midrst_cs_n", mic_cs_n, 1);
      chk("midrst_sclk", mic_sclk, 1);
      chk("midrst_sample", sample, 0);
      chk("midrst_peak", peak, 0);
      rst = 1'b0;
      @(posedge clk_100mhz);
      #1;
      chk("restart_cs_n", mic_cs_n, 0);
      repeat (5) @(posedge clk_100mhz);
      cut = 1'b0;
    end
    for (int i = 0; i < 30000 && exp_q.size() != 0; i++) @(posedge clk_100mhz);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (100) @(posedge clk_100mhz);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
